// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with an in-order output FIFO.
// Define IMM_GEN_PC_TARGET_EN to add the per-entry PC-relative target adder.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  logic [XLEN-1:0]  imm;
  logic             err;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  entry_t           mem [DEPTH];

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (in_imm_src)
      3'b000: imm = XLEN'($signed(in_instr[31:20]));
      3'b001: imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      3'b010: imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0}));
      3'b011: imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0}));
      3'b100: imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      3'b101: imm = XLEN'(in_instr[20 +: SHAMT_W]);
      default: err = 1'b1;
    endcase
  end

  // Gated by rst_n so nothing is accepted on a reset edge.
  assign in_ready  = rst_n && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: storage is not reset; out_valid masks every read of a stale slot.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{imm: imm, tag: in_tag, err: err};
  end

  assign out_imm = out_valid ? mem[rd_ptr].imm : '0;
  assign out_tag = out_valid ? mem[rd_ptr].tag : '0;
  assign out_err = out_valid ? mem[rd_ptr].err : 1'b0;

`ifdef IMM_GEN_PC_TARGET_EN
  logic [XLEN-1:0] tgt_mem [DEPTH];
  logic            unused_opcode;

  always_ff @(posedge clk) begin
    if (push) tgt_mem[wr_ptr] <= in_pc + imm;
  end

  assign out_target    = out_valid ? tgt_mem[rd_ptr] : '0;
  assign unused_opcode = ^in_instr[6:0];
`else
  logic unused_opcode;

  assign out_target    = '0;
  assign unused_opcode = ^{in_instr[6:0], in_pc};
`endif

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts an instruction word, an immediate-format select and the instruction PC through a valid/ready handshake. It extracts and sign-extends the immediate for all RV32I/RV64I formats to XLEN bits, and optionally computes the PC-relative target. Results are buffered in an in-order output FIFO, so decode can absorb execute-side backpressure without stalling fetch by more than DEPTH entries.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- TAG_W, 4: width of the opaque tag carried alongside each result.

- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_instr  in  32  instruction word.
- in_imm_src  in  3  format select (see Operation).
- in_pc  in  XLEN  PC of the instruction.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  head FIFO entry valid.
- out_ready  in  1  consumer takes head entry.
- out_imm  out  XLEN  extended immediate.
- out_target  out  XLEN  in_pc + immediate (macro-dependent).
- out_tag  out  TAG_W  tag of head entry.
- out_err  out  1  head entry used an illegal in_imm_src.

## Operation
- Format encoding of in_imm_src:
  - 000 I: instr[31:20], sign-extended.
  - 001 S: {instr[31:25], instr[11:7]}, sign-extended.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, sign-extended.
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, sign-extended.
  - 100 U: {instr[31:12], 12'b0}; for XLEN=64, sign-extended from bit 31.
  - 101 SHAMT: zero-extended; instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 110/111: illegal; immediate = 0, err = 1, target = in_pc.
- Extraction is combinational on the input beat. The result {imm, target, tag, err} is written into the FIFO on the accepting edge.
- Push: in_valid && in_ready. Pop: out_valid && out_ready. FIFO is strictly in order.
- in_ready = (count < DEPTH). It depends only on registered count, never on out_ready, so there is no combinational in→out path.
- Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
- When full, a pop frees the slot next cycle. The same-cycle push is refused because in_ready=0.
- Pointers wrap modulo DEPTH. count has width clog2(DEPTH+1).
- out_* fields are driven from the head entry. When empty, out_imm/out_target/out_tag/out_err read 0.
- target arithmetic: XLEN-bit modulo-2^XLEN addition; carry out is discarded.

## Timing
- Latency: accepted at edge N → out_valid=1 after edge N, visible in cycle N+1.
- Throughput: one beat per cycle while out_ready=1 and DEPTH≥2.
- Reset (rst_n=0 sampled at rising edge): count=0, pointers=0, out_valid=0, in_ready=0 during the reset cycle and 1 from the first cycle after release. All out_* fields are 0.
- Reset mid-operation discards all buffered entries. No beat is accepted on the reset edge.
- in_* must be held stable while in_valid=1 and in_ready=0. The block does not check this.

## Configuration
- IMM_GEN_PC_TARGET_EN defined: XLEN-bit adder present; out_target = in_pc + immediate, stored per entry.
- IMM_GEN_PC_TARGET_EN undefined: no adder and no target storage. out_target is tied to 0, and in_pc is ignored.

## Test plan
- XLEN=32, I-type 0xFFF00093 (addi x1,x0,-1), src 000, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, err=0.
- S 0x00112623 (sw x1,12(x2)) → 0x0000000C. B 0xFE000EE3, pc 0x100 → imm 0xFFFFFFFC, target 0x000000FC (macro on).
- J 0x001000EF (jal x1,2048), pc 0x1000 → imm 0x00000800, target 0x00001800. U 0x12345037 → 0x12345000. XLEN=64, U 0x80000037 → 0xFFFFFFFF80000000.
- SHAMT: XLEN=64, instr[25:20]=63 → imm 0x3F. src 111 → imm 0, err 1, tag preserved.
- DEPTH=2, out_ready=0, three back-to-back beats tags 1,2,3 → in_ready low after second accept. Raise out_ready → outputs tags 1,2,3 in order, one per cycle.
- Two entries buffered, rst_n=0 for one edge → out_valid=0 and in_ready=0 that cycle. After release, in_ready=1 and no stale entries emerge.
